control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/control_sequencer.sv | 112 +++++++++++
 tb/tb_control_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, ALU codes, sequencer states and control-word layout shared across the CPU
// Contents: OP_* opcode constants (IR[31:27]), ALU_* operation codes,
//           state_t (fetch T0-T2, execute T3-T7, HALT), ctrl_t (one bit per control line).
package cpu_pkg;
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;
    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;
    typedef enum logic [3:0] {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT} state_t;
    typedef struct packed {
        logic pc_out, inc_pc, pc_in, mar_in, mdr_in, mdr_out, ir_in, read, write, ram_enable;
        logic y_in, zlo_in, zlo_out, c_out, gra, grb, grc, r_in, r_out, ba_out, con_in;
        logic zmux_enable, zselect, zmux_out, out_port_enable, port_inout;
    } ctrl_t;
    function automatic logic is_rtype(input logic [4:0] op);
        return op >= OP_ADD && op <= OP_ROL;
    endfunction
endpackage

// File: rtl/control_sequencer.sv
// control_sequencer: Moore FSM issuing per-cycle datapath control for fetch and execute
// Ports: clock, clear (sync active-high); IR (opcode IR[31:27]); CON (branch flag);
//        26 single-bit control strobes; aluControl (ALU op); Run (0 only in HALT).
module control_sequencer
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        CON,
    output logic        PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, read, write, RAMenable,
    output logic        Yin, ZLOin, ZLOout, Cout, Gra, Grb, Grc, Rin, Rout, BAout, conin,
    output logic        ZMuxEnable, ZSelect, ZMuxOut, OutPortenable, PortInout,
    output logic [4:0]  aluControl,
    output logic        Run
);
    state_t state_q, state_d;
    ctrl_t c;
    logic [4:0] op, alu;
    logic rtype, imm, addr, unused_ir;
    assign op = IR[31:27];
    assign unused_ir = ^IR[26:0];
    assign rtype = is_rtype(op);
    assign imm = op == OP_ADDI || op == OP_ANDI || op == OP_ORI;
    // ldi, ld and st all form an effective address Rb + C (Rb = 0 reads as base 0 via BAout)
    assign addr = op == OP_LDI || op == OP_LD || op == OP_ST;
    always_ff @(posedge clock)
        if (clear) state_q <= S_T0;
        else state_q <= state_d;
    always_comb begin
        c = '0;
        alu = '0;
        state_d = state_q;
        case (state_q)
            S_T0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; state_d = S_T1; end
            S_T1: begin c.read = 1'b1; c.ram_enable = 1'b1; c.mdr_in = 1'b1; state_d = S_T2; end
            S_T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; state_d = S_T3; end
            S_T3: begin
                state_d = S_T0;
                if (rtype || imm) begin
                    c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; state_d = S_T4;
                end else if (addr) begin
                    c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; state_d = S_T4;
                end else if (op == OP_BR) begin
                    c.grb = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1; state_d = S_T4;
                end else if (op == OP_MFHI || op == OP_MFLO) begin
                    c.zmux_enable = 1'b1; c.zmux_out = 1'b1; c.zselect = op == OP_MFHI;
                    c.gra = 1'b1; c.r_in = 1'b1;
                end else if (op == OP_IN) begin
                    c.port_inout = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
                end else if (op == OP_OUT) begin
                    c.gra = 1'b1; c.r_out = 1'b1; c.out_port_enable = 1'b1;
                end else if (op == OP_JR) begin
                    c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1;
                end else if (op != OP_NOP) state_d = S_HALT;
            end
            S_T4: begin
                state_d = S_T5;
                if (rtype) begin
                    c.grc = 1'b1; c.r_out = 1'b1; c.zlo_in = 1'b1; alu = op;
                end else if (op == OP_BR) begin
                    c.pc_out = 1'b1; c.y_in = 1'b1;
                end else begin
                    c.c_out = 1'b1; c.zlo_in = 1'b1;
                    alu = op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : ALU_ADD;
                end
            end
            S_T5: begin
                state_d = S_T0;
                if (op == OP_BR) begin
                    c.c_out = 1'b1; c.zlo_in = 1'b1; alu = ALU_ADD; state_d = S_T6;
                end else if (op == OP_LD || op == OP_ST) begin
                    c.zlo_out = 1'b1; c.mar_in = 1'b1; state_d = S_T6;
                end else begin
                    c.zlo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
                end
            end
            S_T6: begin
                state_d = S_T7;
                if (op == OP_LD) begin
                    c.read = 1'b1; c.ram_enable = 1'b1; c.mdr_in = 1'b1;
                end else if (op == OP_ST) begin
                    c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1;
                end else begin
                    c.zlo_out = 1'b1; c.pc_in = CON; state_d = S_T0;
                end
            end
            S_T7: begin
                state_d = S_T0;
                if (op == OP_LD) begin
                    c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
                end else begin
                    c.write = 1'b1; c.ram_enable = 1'b1;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_T0;
        endcase
        if (clear) begin
            c = '0;
            alu = '0;
        end
    end
    assign {PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, read, write, RAMenable} =
        {c.pc_out, c.inc_pc, c.pc_in, c.mar_in, c.mdr_in, c.mdr_out, c.ir_in, c.read, c.write, c.ram_enable};
    assign {Yin, ZLOin, ZLOout, Cout, Gra, Grb, Grc, Rin, Rout, BAout, conin} =
        {c.y_in, c.zlo_in, c.zlo_out, c.c_out, c.gra, c.grb, c.grc, c.r_in, c.r_out, c.ba_out, c.con_in};
    assign {ZMuxEnable, ZSelect, ZMuxOut, OutPortenable, PortInout} =
        {c.zmux_enable, c.zselect, c.zmux_out, c.out_port_enable, c.port_inout};
    assign aluControl = alu;
    assign Run = clear || state_q != S_HALT;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed per-instruction checks of the control sequencer
module tb_control_sequencer;
    logic clock = 1'b0, clear = 1'b0, CON = 1'b0;
    logic [31:0] IR = '0;
    logic PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, read, write, RAMenable;
    logic Yin, ZLOin, ZLOout, Cout, Gra, Grb, Grc, Rin, Rout, BAout, conin;
    logic ZMuxEnable, ZSelect, ZMuxOut, OutPortenable, PortInout, Run;
    logic [4:0] aluControl;
    logic [25:0] obs;
    int checks = 0, errors = 0;

    localparam logic [25:0] PCOUT = 26'd1 << 25, INCPC = 26'd1 << 24, PCIN = 26'd1 << 23;
    localparam logic [25:0] MARIN = 26'd1 << 22, MDRIN = 26'd1 << 21, MDROUT = 26'd1 << 20;
    localparam logic [25:0] IRIN = 26'd1 << 19, READ = 26'd1 << 18, WRITE = 26'd1 << 17;
    localparam logic [25:0] RAMEN = 26'd1 << 16, YIN = 26'd1 << 15, ZLOIN = 26'd1 << 14;
    localparam logic [25:0] ZLOOUT = 26'd1 << 13, COUT = 26'd1 << 12, GRA = 26'd1 << 11;
    localparam logic [25:0] GRB = 26'd1 << 10, GRC = 26'd1 << 9, RIN = 26'd1 << 8;
    localparam logic [25:0] ROUT = 26'd1 << 7, BAOUT = 26'd1 << 6, CONIN = 26'd1 << 5;
    localparam logic [25:0] ZMUXEN = 26'd1 << 4, ZSEL = 26'd1 << 3, ZMUXOUT = 26'd1 << 2;
    localparam logic [25:0] OUTPEN = 26'd1 << 1, PORTIO = 26'd1;
    localparam logic [25:0] F0 = PCOUT | MARIN | INCPC, F1 = READ | RAMEN | MDRIN, F2 = MDROUT | IRIN;

    control_sequencer dut (
        .clock(clock), .clear(clear), .IR(IR), .CON(CON),
        .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .read(read), .write(write), .RAMenable(RAMenable),
        .Yin(Yin), .ZLOin(ZLOin), .ZLOout(ZLOout), .Cout(Cout), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .conin(conin),
        .ZMuxEnable(ZMuxEnable), .ZSelect(ZSelect), .ZMuxOut(ZMuxOut),
        .OutPortenable(OutPortenable), .PortInout(PortInout),
        .aluControl(aluControl), .Run(Run)
    );

    assign obs = {PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, read, write, RAMenable,
                  Yin, ZLOin, ZLOout, Cout, Gra, Grb, Grc, Rin, Rout, BAout, conin,
                  ZMuxEnable, ZSelect, ZMuxOut, OutPortenable, PortInout};

    always #5 clock = ~clock;

    // Clear for one edge with the given instruction loaded; returns mid-cycle in T0 with clear low.
    task automatic start(input logic [4:0] op, input logic con);
        @(negedge clock);
        clear = 1'b1;
        IR = {op, 27'h2A5_1C3};
        CON = con;
        @(negedge clock);
        clear = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        @(negedge clock);
        clear = 1'b1;
        IR = {5'b00011, 27'h0};
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({obs, aluControl, Run} !== {26'd0, 5'd0, 1'b1}) begin
                errors++;
                $display("FAIL reset cyc%0d: got ctrl=%h alu=%b run=%b, want ctrl=0 alu=00000 run=1", i, obs, aluControl, Run);
            end
            @(negedge clock);
        end
        clear = 1'b0;
        #1;
        checks++;
        if ({obs, aluControl, Run} !== {F0, 5'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_first_fetch: got ctrl=%h run=%b, want ctrl=%h run=1", obs, Run, F0);
        end
    endtask

    task automatic test_add;
        logic [25:0] e [7] = '{F0, F1, F2, GRB | ROUT | YIN, GRC | ROUT | ZLOIN, ZLOOUT | GRA | RIN, F0};
        logic [4:0] a [7] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'd0, 5'd0};
        start(5'b00011, 1'b0);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if ({obs, aluControl, Run} !== {e[i], a[i], 1'b1}) begin
                errors++;
                $display("FAIL add cyc%0d: got ctrl=%h alu=%b run=%b, want ctrl=%h alu=%b run=1", i, obs, aluControl, Run, e[i], a[i]);
            end
            @(negedge clock); #1;
        end
    endtask

    task automatic test_ld;
        logic [25:0] e [9] = '{F0, F1, F2, GRB | BAOUT | YIN, COUT | ZLOIN, ZLOOUT | MARIN,
                               READ | RAMEN | MDRIN, MDROUT | GRA | RIN, F0};
        logic [4:0] a [9] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'd0, 5'd0, 5'd0, 5'd0};
        start(5'b00000, 1'b0);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if ({obs, aluControl, Run} !== {e[i], a[i], 1'b1}) begin
                errors++;
                $display("FAIL ld cyc%0d: got ctrl=%h alu=%b run=%b, want ctrl=%h alu=%b run=1", i, obs, aluControl, Run, e[i], a[i]);
            end
            @(negedge clock); #1;
        end
    endtask

    task automatic test_imm;
        logic [4:0] ops [3] = '{5'b01100, 5'b01101, 5'b01110};
        logic [4:0] codes [3] = '{5'b00011, 5'b00101, 5'b00110};
        logic [25:0] e [7] = '{F0, F1, F2, GRB | ROUT | YIN, COUT | ZLOIN, ZLOOUT | GRA | RIN, F0};
        for (int k = 0; k < 3; k++) begin
            start(ops[k], 1'b0);
            for (int i = 0; i < 7; i++) begin
                checks++;
                if ({obs, aluControl, Run} !== {e[i], (i == 4) ? codes[k] : 5'd0, 1'b1}) begin
                    errors++;
                    $display("FAIL imm op%b cyc%0d: got ctrl=%h alu=%b run=%b, want ctrl=%h alu=%b run=1",
                             ops[k], i, obs, aluControl, Run, e[i], (i == 4) ? codes[k] : 5'd0);
                end
                @(negedge clock); #1;
            end
        end
    endtask

    task automatic test_br;
        logic [4:0] a [8] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'd0, 5'd0};
        for (int k = 0; k < 2; k++) begin
            logic [25:0] e [8] = '{F0, F1, F2, GRB | ROUT | CONIN, PCOUT | YIN, COUT | ZLOIN,
                                   ZLOOUT | ((k == 1) ? PCIN : 26'd0), F0};
            start(5'b10010, k[0]);
            for (int i = 0; i < 8; i++) begin
                checks++;
                if ({obs, aluControl, Run} !== {e[i], a[i], 1'b1}) begin
                    errors++;
                    $display("FAIL br con%0d cyc%0d: got ctrl=%h alu=%b run=%b, want ctrl=%h alu=%b run=1", k, i, obs, aluControl, Run, e[i], a[i]);
                end
                @(negedge clock); #1;
            end
        end
    endtask

    task automatic test_single_cycle;
        logic [4:0] ops [6] = '{5'b11001, 5'b11000, 5'b10110, 5'b10111, 5'b10011, 5'b11010};
        logic [25:0] t3 [6] = '{ZMUXEN | ZMUXOUT | GRA | RIN, ZMUXEN | ZMUXOUT | ZSEL | GRA | RIN,
                                PORTIO | GRA | RIN, GRA | ROUT | OUTPEN, GRA | ROUT | PCIN, 26'd0};
        for (int k = 0; k < 6; k++) begin
            logic [25:0] e [5] = '{F0, F1, F2, t3[k], F0};
            start(ops[k], 1'b0);
            for (int i = 0; i < 5; i++) begin
                checks++;
                if ({obs, aluControl, Run} !== {e[i], 5'd0, 1'b1}) begin
                    errors++;
                    $display("FAIL op%b cyc%0d: got ctrl=%h alu=%b run=%b, want ctrl=%h alu=00000 run=1", ops[k], i, obs, aluControl, Run, e[i]);
                end
                @(negedge clock); #1;
            end
        end
    endtask

    task automatic test_halt;
        logic [25:0] e [14] = '{F0, F1, F2, 26'd0, 26'd0, 26'd0, 26'd0, 26'd0, 26'd0, 26'd0, 26'd0, 26'd0, 26'd0, 26'd0};
        start(5'b11111, 1'b0);
        for (int i = 0; i < 14; i++) begin
            checks++;
            if ({obs, aluControl, Run} !== {e[i], 5'd0, i < 4}) begin
                errors++;
                $display("FAIL halt cyc%0d: got ctrl=%h alu=%b run=%b, want ctrl=%h alu=00000 run=%b", i, obs, aluControl, Run, e[i], i < 4);
            end
            @(negedge clock); #1;
        end
        clear = 1'b1;
        #1;
        checks++;
        if ({obs, aluControl, Run} !== {26'd0, 5'd0, 1'b1}) begin
            errors++;
            $display("FAIL halt_clear: got ctrl=%h alu=%b run=%b, want ctrl=0 alu=00000 run=1", obs, aluControl, Run);
        end
        @(negedge clock);
        clear = 1'b0;
        #1;
        checks++;
        if ({obs, Run} !== {F0, 1'b1}) begin
            errors++;
            $display("FAIL halt_restart: got ctrl=%h run=%b, want ctrl=%h run=1", obs, Run, F0);
        end
    endtask

    task automatic test_st_abort;
        logic [25:0] e [7] = '{F0, F1, F2, GRB | BAOUT | YIN, COUT | ZLOIN, ZLOOUT | MARIN, GRA | ROUT | MDRIN};
        logic [4:0] a [7] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'd0, 5'd0};
        start(5'b00010, 1'b0);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if ({obs, aluControl, Run} !== {e[i], a[i], 1'b1}) begin
                errors++;
                $display("FAIL st cyc%0d: got ctrl=%h alu=%b run=%b, want ctrl=%h alu=%b run=1", i, obs, aluControl, Run, e[i], a[i]);
            end
            if (i < 6) begin
                @(negedge clock); #1;
            end
        end
        clear = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({obs, aluControl, Run} !== {26'd0, 5'd0, 1'b1}) begin
                errors++;
                $display("FAIL st_abort cyc%0d: got ctrl=%h alu=%b run=%b write=%b, want ctrl=0 run=1 write=0", i, obs, aluControl, Run, write);
            end
            @(negedge clock);
        end
        clear = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({obs, Run} !== {(i == 0) ? F0 : F1, 1'b1}) begin
                errors++;
                $display("FAIL st_resume cyc%0d: got ctrl=%h run=%b, want ctrl=%h run=1", i, obs, Run, (i == 0) ? F0 : F1);
            end
            @(negedge clock); #1;
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_ld;
        test_imm;
        test_br;
        test_single_cycle;
        test_halt;
        test_st_abort;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
